clk_divider_preset: RTL and testbench

CLK_DIVIDER_PRESET -- requirements
Module: clk_divider_preset

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_tc_mux.sv | 32 +++
 rtl/clk_divider_preset.sv | 141 ++++++++++++++
 tb/tb_clk_divider_preset.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the preset clock divider: FSM states and default
// half-period terminal counts.
package clk_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStop
    } state_t;

    localparam int unsigned DIV0_DEF = 4999;
    localparam int unsigned DIV1_DEF = 49999;
    localparam int unsigned DIV2_DEF = 499999;
    localparam int unsigned DIV3_DEF = 4999999;

endpackage

// File: rtl/clk_div_tc_mux.sv
// Combinational preset selector to half-period terminal count lookup.
// Selector values outside 0..3 fall back to DIV1.
module clk_div_tc_mux
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = 24,
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DIV0  = DIV0_DEF,
    parameter int unsigned DIV1  = DIV1_DEF,
    parameter int unsigned DIV2  = DIV2_DEF,
    parameter int unsigned DIV3  = DIV3_DEF
) (
    input  logic [SEL_W-1:0] sel,
    output logic [CNT_W-1:0] tc
);

    logic [31:0] sel_ext;

    assign sel_ext = 32'(sel);

    always_comb begin
        tc = CNT_W'(DIV1);
        case (sel_ext)
            32'd0:   tc = CNT_W'(DIV0);
            32'd1:   tc = CNT_W'(DIV1);
            32'd2:   tc = CNT_W'(DIV2);
            32'd3:   tc = CNT_W'(DIV3);
            default: tc = CNT_W'(DIV1);
        endcase
    end

endmodule

// File: rtl/clk_divider_preset.sv
// Clock divider with four selectable presets; preset changes are deferred to
// the falling edge of divided_clk so no phase is ever truncated.
module clk_divider_preset
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned SEL_W     = 2,
    parameter int unsigned DIV0      = DIV0_DEF,
    parameter int unsigned DIV1      = DIV1_DEF,
    parameter int unsigned DIV2      = DIV2_DEF,
    parameter int unsigned DIV3      = DIV3_DEF,
    parameter int unsigned RESET_SEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic             divided_clk,
    output logic             tick,
    output logic [SEL_W-1:0] sel_active,
    output logic             switching
);

    if (((64'(DIV0) >> CNT_W) != 64'd0) || ((64'(DIV1) >> CNT_W) != 64'd0) ||
        ((64'(DIV2) >> CNT_W) != 64'd0) || ((64'(DIV3) >> CNT_W) != 64'd0)) begin : g_div_range
        $fatal(1, "clk_divider_preset: a DIVn value does not fit in CNT_W bits");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               tick_q, tick_d;
    logic [SEL_W-1:0]   sel_active_q, sel_active_d;
    logic               pend_q, pend_d;
    logic [CNT_W-1:0]   tc;
    logic               term;

    clk_div_tc_mux #(
        .CNT_W (CNT_W),
        .SEL_W (SEL_W),
        .DIV0  (DIV0),
        .DIV1  (DIV1),
        .DIV2  (DIV2),
        .DIV3  (DIV3)
    ) u_tc_mux (
        .sel (sel_active_q),
        .tc  (tc)
    );

    assign term = (cnt_q == tc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            div_q        <= 1'b0;
            tick_q       <= 1'b0;
            sel_active_q <= SEL_W'(RESET_SEL);
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            tick_q       <= tick_d;
            sel_active_q <= sel_active_d;
            pend_q       <= pend_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        tick_d       = 1'b0;
        sel_active_d = sel_active_q;
        pend_d       = pend_q;

        case (state_q)
            StIdle: begin
                cnt_d        = '0;
                div_d        = 1'b0;
                sel_active_d = sel;
                pend_d       = 1'b0;
                if (en) begin
                    state_d = StRun;
                end
            end
            StRun, StStop: begin
                pend_d = (sel != sel_active_q);
                if (term) begin
                    cnt_d = '0;
                    div_d = ~div_q;
                    if (div_q) begin
                        // Falling edge: the latest requested preset takes over here.
                        sel_active_d = sel;
                        pend_d       = 1'b0;
                    end else if (state_q == StRun) begin
                        tick_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end

                if (state_q == StRun) begin
                    if (!en) begin
                        if (!div_q) begin
                            // Low phase carries no pulse worth finishing; abandon it.
                            state_d = StIdle;
                            cnt_d   = '0;
                            div_d   = 1'b0;
                            tick_d  = 1'b0;
                            pend_d  = 1'b0;
                        end else if (term) begin
                            state_d = StIdle;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = StStop;
                        end
                    end
                end else if (en) begin
                    state_d = StRun;
                end else if (term) begin
                    state_d = StIdle;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                div_d   = 1'b0;
                pend_d  = 1'b0;
            end
        endcase
    end

    assign divided_clk = div_q;
    assign tick        = tick_q;
    assign sel_active  = sel_active_q;
    assign switching   = pend_q;

endmodule

// File: tb/tb_clk_divider_preset.sv
// Scoreboard bench for clk_divider_preset with small terminal counts
// (DIV0=1, DIV1=3, DIV2=0, DIV3=7) so every phase length is easy to follow.
module tb_clk_divider_preset;
    import clk_div_pkg::*;

    typedef struct {
        int div;
        int tick;
        int sw;
        int sa;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] sel;
    logic       divided_clk;
    logic       tick;
    logic [1:0] sel_active;
    logic       switching;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    clk_divider_preset #(
        .CNT_W     (4),
        .SEL_W     (2),
        .DIV0      (1),
        .DIV1      (3),
        .DIV2      (0),
        .DIV3      (7),
        .RESET_SEL (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sel         (sel),
        .divided_clk (divided_clk),
        .tick        (tick),
        .sel_active  (sel_active),
        .switching   (switching)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t x;
        check_eq({tag, ".queue"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() == 0) return;
        x = exp_q.pop_front();
        check_eq({tag, ".div"},  32'(divided_clk), 32'(x.div));
        check_eq({tag, ".tick"}, 32'(tick),        32'(x.tick));
        check_eq({tag, ".sw"},   32'(switching),   32'(x.sw));
        check_eq({tag, ".sa"},   32'(sel_active),  32'(x.sa));
    endtask

    task automatic expect_now(input string tag, input int xd, input int xt, input int xs,
                              input int xa);
        exp_q.push_back('{xd, xt, xs, xa});
        pop_check(tag);
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
    task automatic cyc(input logic e, input logic [1:0] s, input int xd, input int xt,
                       input int xs, input int xa, input string tag);
        en  = e;
        sel = s;
        exp_q.push_back('{xd, xt, xs, xa});
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        sel = 2'd0;
        #2 rst = 1'b1;
        #1;
        expect_now("RST", 0, 0, 0, 1);
        check_eq("RST.state", 32'(dut.state_q), 32'(StIdle));
        check_eq("RST.cnt", 32'(dut.cnt_q), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // TC=1: two low cycles after RUN entry, then 2 high / 2 low.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 2'd0, ((i >> 1) & 1), (i % 4 == 2) ? 1 : 0, 0, 0, $sformatf("A%0d", i));
        end

        // Switch to TC=3 during the first high cycle.
        cyc(1'b1, 2'd0, 1, 1, 0, 0, "B0");
        for (int j = 1; j <= 10; j++) begin
            cyc(1'b1, 2'd1, (j == 1 || (j >= 6 && j <= 9)) ? 1 : 0, (j == 6) ? 1 : 0,
                (j == 1) ? 1 : 0, (j == 1) ? 0 : 1, $sformatf("B%0d", j));
        end

        // 1 -> 3 -> 2 within one period; only 2 is applied, giving 1-cycle phases.
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, (k < 3) ? 2'd3 : 2'd2,
                (k < 4) ? 0 : (k < 8) ? 1 : ((k - 8) & 1),
                (k == 4 || (k >= 8 && ((k - 8) & 1) == 1)) ? 1 : 0,
                (k < 8) ? 1 : 0, (k < 8) ? 1 : 2, $sformatf("C%0d", k));
        end

        // Back to TC=3, then drop en in the second high cycle.
        cyc(1'b1, 2'd1, 1, 1, 1, 2, "D0");
        cyc(1'b1, 2'd1, 0, 0, 0, 1, "D1");
        for (int m = 1; m <= 3; m++) cyc(1'b1, 2'd1, 0, 0, 0, 1, $sformatf("D_low%0d", m));
        cyc(1'b1, 2'd1, 1, 1, 0, 1, "D_rise");
        cyc(1'b1, 2'd1, 1, 0, 0, 1, "D_hi2");
        cyc(1'b0, 2'd1, 1, 0, 0, 1, "D_stop1");
        check_eq("D.state_stop", 32'(dut.state_q), 32'(StStop));
        cyc(1'b0, 2'd1, 1, 0, 0, 1, "D_stop2");
        cyc(1'b0, 2'd1, 0, 0, 0, 1, "D_fall");
        check_eq("D.state_idle", 32'(dut.state_q), 32'(StIdle));
        check_eq("D.cnt", 32'(dut.cnt_q), 32'd0);
        for (int m = 0; m < 2; m++) cyc(1'b0, 2'd1, 0, 0, 0, 1, $sformatf("D_idle%0d", m));

        // TC=7 run, then asynchronous reset in the first high cycle with a change pending.
        cyc(1'b1, 2'd3, 0, 0, 0, 3, "E1");
        for (int e = 2; e <= 8; e++) cyc(1'b1, 2'd3, 0, 0, 0, 3, $sformatf("E%0d", e));
        cyc(1'b1, 2'd0, 1, 1, 1, 3, "E9");
        #2 rst = 1'b1;
        #1;
        expect_now("E_rst_async", 0, 0, 0, 1);
        en = 1'b0;
        @(posedge clk);
        #1;
        expect_now("E_rst_held", 0, 0, 0, 1);
        rst = 1'b0;
        cyc(1'b0, 2'd2, 0, 0, 0, 2, "E_idle0");
        cyc(1'b0, 2'd2, 0, 0, 0, 2, "E_idle1");
        check_eq("E.state", 32'(dut.state_q), 32'(StIdle));

        // TC=0: toggle every cycle, tick on every rise.
        for (int f = 1; f <= 8; f++) begin
            cyc(1'b1, 2'd2, (f >= 2 && f % 2 == 0) ? 1 : 0, (f >= 2 && f % 2 == 0) ? 1 : 0,
                0, 2, $sformatf("F%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
